// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// Select/op encodings match the datapath mux ordering.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        FAULT    = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [1:0] ALU_A_PC    = 2'd0;
    localparam logic [1:0] ALU_A_RS1   = 2'd1;
    localparam logic [1:0] ALU_A_OLDPC = 2'd2;

    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_FOUR = 2'd1;
    localparam logic [1:0] ALU_B_IMM  = 2'd2;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_JAL    = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_LINK   = 2'd2;

endpackage

// File: rtl/mc_mem_timer.sv
// Memory wait counter: counts stalled request cycles and flags the cycle
// in which one more stall would reach MEM_TIMEOUT.
module mc_mem_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMER_W     = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [TIMER_W-1:0] LAST_WAIT = TIMER_W'(MEM_TIMEOUT - 1);

    logic [TIMER_W-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_reg <= '0;
        end else if (clear_i) begin
            count_reg <= '0;
        end else if (inc_i) begin
            count_reg <= count_reg + TIMER_W'(1);
        end
    end

    // Only a stalled cycle can expire, so a late ready still wins.
    assign expired_o = inc_i && (count_reg == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM sharing one memory port for instructions
// and data; drives every datapath enable and mux select.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMER_W     = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        ir_write_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        iord_o,
    output logic        reg_write_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  pc_src_o,
    output logic [1:0]  mem_to_reg_o,
    output logic [3:0]  state_o,
    output logic        fault_o
);

    state_t state_reg, state_next;

    logic       pc_write, ir_write, mem_req, mem_we, iord, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg;
    logic       timer_expired;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = instr_i[6:0];
    assign funct3            = instr_i[14:12];
    assign unused_instr_bits = ^{instr_i[31:15], instr_i[11:7]};

    mc_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TIMER_W    (TIMER_W)
    ) u_mem_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!mem_req || mem_ready_i),
        .inc_i    (mem_req && !mem_ready_i),
        .expired_o(timer_expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = ALU_A_PC;
        alu_src_b  = ALU_B_RS2;
        alu_op     = ALU_OP_ADD;
        pc_src     = PC_SRC_ALU;
        mem_to_reg = M2R_ALUOUT;
        case (state_reg)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ALU_B_FOUR;
                if (mem_ready_i) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end else if (timer_expired) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                // ALUOut captures oldPC + imm for a possible branch/jal.
                alu_src_a = ALU_A_OLDPC;
                alu_src_b = ALU_B_IMM;
                case (opcode)
                    OP_R:               state_next = EXEC_R;
                    OP_I:               state_next = EXEC_I;
                    OP_LOAD, OP_STORE:  state_next = MEM_ADDR;
                    OP_BRANCH:          state_next = BRANCH;
                    OP_JAL:             state_next = JAL;
                    default:            state_next = FAULT;
                endcase
            end
            EXEC_R: begin
                alu_src_a  = ALU_A_RS1;
                alu_src_b  = ALU_B_RS2;
                alu_op     = ALU_OP_FUNCT;
                state_next = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a  = ALU_A_RS1;
                alu_src_b  = ALU_B_IMM;
                alu_op     = ALU_OP_FUNCT;
                state_next = WB_ALU;
            end
            WB_ALU: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a  = ALU_A_RS1;
                alu_src_b  = ALU_B_IMM;
                state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD, MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (state_reg == MEM_WR);
                if (mem_ready_i) begin
                    state_next = (state_reg == MEM_RD) ? WB_MEM : FETCH;
                end else if (timer_expired) begin
                    state_next = FAULT;
                end
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a = ALU_A_RS1;
                alu_src_b = ALU_B_RS2;
                alu_op    = ALU_OP_SUB;
                pc_src    = PC_SRC_TARGET;
                if (funct3 == F3_BEQ) begin
                    pc_write   = zero_i;
                    state_next = FETCH;
                end else begin
                    state_next = FAULT;
                end
            end
            JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_LINK;
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JAL;
                state_next = FETCH;
            end
            FAULT:   state_next = FAULT;
            default: state_next = FAULT;
        endcase
    end

    // Reset forces every output low immediately, abandoning any access.
    assign pc_write_o   = rst_i && pc_write;
    assign ir_write_o   = rst_i && ir_write;
    assign mem_req_o    = rst_i && mem_req;
    assign mem_we_o     = rst_i && mem_we;
    assign iord_o       = rst_i && iord;
    assign reg_write_o  = rst_i && reg_write;
    assign alu_src_a_o  = rst_i ? alu_src_a  : 2'd0;
    assign alu_src_b_o  = rst_i ? alu_src_b  : 2'd0;
    assign alu_op_o     = rst_i ? alu_op     : 2'd0;
    assign pc_src_o     = rst_i ? pc_src     : 2'd0;
    assign mem_to_reg_o = rst_i ? mem_to_reg : 2'd0;
    assign state_o      = state_reg;
    assign fault_o      = rst_i && (state_reg == FAULT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instructions cycle by cycle and
// compares the full output vector against hand-derived expectations.
module tb_multicycle_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        pc_write_o, ir_write_o, mem_req_o, mem_we_o, iord_o, reg_write_o;
    logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o, mem_to_reg_o;
    logic [3:0]  state_o;
    logic        fault_o;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .TIMER_W(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .instr_i     (instr_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .pc_write_o  (pc_write_o),
        .ir_write_o  (ir_write_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .iord_o      (iord_o),
        .reg_write_o (reg_write_o),
        .alu_src_a_o (alu_src_a_o),
        .alu_src_b_o (alu_src_b_o),
        .alu_op_o    (alu_op_o),
        .pc_src_o    (pc_src_o),
        .mem_to_reg_o(mem_to_reg_o),
        .state_o     (state_o),
        .fault_o     (fault_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    localparam logic [31:0] I_ADD  = 32'h002081B3;  // add  x3,x1,x2
    localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_LW   = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] I_SW   = 32'h0050A223;  // sw   x5,4(x1)
    localparam logic [31:0] I_BEQ  = 32'h00208463;  // beq  x1,x2,8
    localparam logic [31:0] I_JAL  = 32'h010000EF;  // jal  x1,16
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    // {state, pcw, irw, req, we, iord, rw, a, b, op, pc_src, m2r, fault}
    localparam logic [20:0] V_RST     = 21'd0;
    localparam logic [20:0] V_FETCH_W = {4'd0,  6'b001000, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [20:0] V_FETCH_R = {4'd0,  6'b111000, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [20:0] V_DEC     = {4'd1,  6'b000000, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [20:0] V_EXR     = {4'd2,  6'b000000, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0};
    localparam logic [20:0] V_EXI     = {4'd3,  6'b000000, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 1'b0};
    localparam logic [20:0] V_MADDR   = {4'd4,  6'b000000, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [20:0] V_MRD     = {4'd5,  6'b001010, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [20:0] V_MWR     = {4'd6,  6'b001110, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [20:0] V_WBA     = {4'd7,  6'b000001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    localparam logic [20:0] V_WBM     = {4'd8,  6'b000001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0};
    localparam logic [20:0] V_BR_T    = {4'd9,  6'b100000, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 1'b0};
    localparam logic [20:0] V_BR_N    = {4'd9,  6'b000000, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 1'b0};
    localparam logic [20:0] V_JAL     = {4'd10, 6'b100001, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0};
    localparam logic [20:0] V_FAULT   = {4'd11, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1};

    task automatic chk(input string tag, input logic [20:0] exp);
        logic [20:0] obs;
        obs = {state_o, pc_write_o, ir_write_o, mem_req_o, mem_we_o, iord_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o, mem_to_reg_o, fault_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
        end
        $display("check %0d %s: state=%0d outputs=%06h", checks, tag, state_o, obs);
    endtask

    // Entered at a falling edge: drive inputs, check, advance one cycle.
    task automatic step(input string tag, input logic [31:0] ins, input logic z,
                        input logic rdy, input logic [20:0] exp);
        instr_i     = ins;
        zero_i      = z;
        mem_ready_i = rdy;
        #1;
        chk(tag, exp);
        @(negedge clk_i);
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b0;
        #1;
        chk(tag, V_RST);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i       = 1'b0;
        instr_i     = 32'd0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("reset_state", V_RST);
        @(negedge clk_i);
        rst_i = 1'b1;

        step("add_fetch", I_ADD, 1'b0, 1'b1, V_FETCH_R);
        step("add_dec",   I_ADD, 1'b0, 1'b0, V_DEC);
        step("add_exec",  I_ADD, 1'b0, 1'b0, V_EXR);
        step("add_wb",    I_ADD, 1'b0, 1'b0, V_WBA);

        step("addi_fetch", I_ADDI, 1'b0, 1'b1, V_FETCH_R);
        step("addi_dec",   I_ADDI, 1'b0, 1'b0, V_DEC);
        step("addi_exec",  I_ADDI, 1'b0, 1'b0, V_EXI);
        step("addi_wb",    I_ADDI, 1'b0, 1'b0, V_WBA);

        step("lw_fetch", I_LW, 1'b0, 1'b1, V_FETCH_R);
        step("lw_dec",   I_LW, 1'b0, 1'b0, V_DEC);
        step("lw_addr",  I_LW, 1'b0, 1'b0, V_MADDR);
        for (int i = 0; i < 3; i++) step("lw_rd_wait", I_LW, 1'b0, 1'b0, V_MRD);
        step("lw_rd_done", I_LW, 1'b0, 1'b1, V_MRD);
        step("lw_wb",      I_LW, 1'b0, 1'b0, V_WBM);

        step("sw_fetch", I_SW, 1'b0, 1'b1, V_FETCH_R);
        step("sw_dec",   I_SW, 1'b0, 1'b0, V_DEC);
        step("sw_addr",  I_SW, 1'b0, 1'b0, V_MADDR);
        step("sw_wr",    I_SW, 1'b0, 1'b1, V_MWR);

        step("beq_t_fetch", I_BEQ, 1'b1, 1'b1, V_FETCH_R);
        step("beq_t_dec",   I_BEQ, 1'b1, 1'b0, V_DEC);
        step("beq_taken",   I_BEQ, 1'b1, 1'b0, V_BR_T);
        step("beq_n_fetch", I_BEQ, 1'b0, 1'b1, V_FETCH_R);
        step("beq_n_dec",   I_BEQ, 1'b0, 1'b0, V_DEC);
        step("beq_not",     I_BEQ, 1'b0, 1'b0, V_BR_N);

        step("jal_fetch", I_JAL, 1'b0, 1'b1, V_FETCH_R);
        step("jal_dec",   I_JAL, 1'b0, 1'b0, V_DEC);
        step("jal_exec",  I_JAL, 1'b0, 1'b0, V_JAL);

        // Ready on the 16th fetch cycle still completes normally.
        for (int i = 0; i < 15; i++) step("rdy16_wait", I_ADD, 1'b0, 1'b0, V_FETCH_W);
        step("rdy16_done", I_ADD, 1'b0, 1'b1, V_FETCH_R);
        step("rdy16_dec",  I_ADD, 1'b0, 1'b0, V_DEC);
        step("rdy16_exec", I_ADD, 1'b0, 1'b0, V_EXR);
        step("rdy16_wb",   I_ADD, 1'b0, 1'b0, V_WBA);

        // Asynchronous reset in the middle of a pending store.
        step("rst_sw_fetch", I_SW, 1'b0, 1'b1, V_FETCH_R);
        step("rst_sw_dec",   I_SW, 1'b0, 1'b0, V_DEC);
        step("rst_sw_addr",  I_SW, 1'b0, 1'b0, V_MADDR);
        mem_ready_i = 1'b0;
        #1;
        chk("rst_sw_pending", V_MWR);
        #1;
        rst_i = 1'b0;
        #1;
        chk("async_rst_now", V_RST);
        @(negedge clk_i);
        #1;
        chk("async_rst_held", V_RST);
        @(negedge clk_i);
        rst_i = 1'b1;
        step("post_rst_fetch", I_ADDI, 1'b0, 1'b1, V_FETCH_R);
        step("post_rst_dec",   I_ADDI, 1'b0, 1'b0, V_DEC);
        step("post_rst_exec",  I_ADDI, 1'b0, 1'b0, V_EXI);
        step("post_rst_wb",    I_ADDI, 1'b0, 1'b0, V_WBA);

        step("bad_fetch", I_BAD, 1'b0, 1'b1, V_FETCH_R);
        step("bad_dec",   I_BAD, 1'b0, 1'b0, V_DEC);
        step("bad_fault", I_BAD, 1'b0, 1'b1, V_FAULT);
        step("bad_sticky", I_ADD, 1'b1, 1'b1, V_FAULT);
        do_reset("bad_reset");

        // Sixteen stalled fetch cycles expire into FAULT.
        for (int i = 0; i < 16; i++) step("to_wait", I_ADD, 1'b0, 1'b0, V_FETCH_W);
        step("to_fault",  I_ADD, 1'b0, 1'b1, V_FAULT);
        step("to_sticky", I_ADD, 1'b0, 1'b1, V_FAULT);
        do_reset("to_reset");
        step("to_recover", I_ADD, 1'b0, 1'b1, V_FETCH_R);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM that turns the single-cycle RV32I datapath into a multi-cycle machine sharing one memory port for instructions and data. It sits beside the PC, instruction register, register file, ALU and ALU_Ctrl, and replaces the combinational Decoder as the source of every write enable and mux select. Each instruction is sequenced through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, and every memory access uses a req/ready handshake.

Parameters:
MEM_TIMEOUT, 16, maximum cycles mem_req_o may wait for mem_ready_i before FAULT (1..255)
TIMER_W, 8, width of the wait counter; must satisfy 2^TIMER_W > MEM_TIMEOUT

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset, asynchronous, active-low
instr_i  in  32  instruction register contents (IR output)
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory handshake; completes the access in the cycle it is high
pc_write_o  out  1  PC load enable
ir_write_o  out  1  IR load enable
mem_req_o  out  1  memory access request
mem_we_o  out  1  memory write (valid only with mem_req_o)
iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
reg_write_o  out  1  register-file write enable
alu_src_a_o  out  2  0 = PC, 1 = rs1, 2 = oldPC
alu_src_b_o  out  2  0 = rs2, 1 = constant 4, 2 = immediate
alu_op_o  out  2  to ALU_Ctrl: 00 add, 01 sub/compare, 10 funct-decoded
pc_src_o  out  2  0 = ALU result, 1 = ALUOut (target), 2 = ALUOut (jal)
mem_to_reg_o  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link)
state_o  out  4  current state encoding, for debug
fault_o  out  1  sticky error flag

Behaviour:
- Reset (rst_i low, asynchronous): state = FETCH, wait counter = 0, fault_o = 0. All enable outputs are 0 while reset is held; selects are 0. Reset mid-access abandons the access without any write.
- Outputs are Moore decodes of state plus mem_ready_i/zero_i qualifiers. Any output not listed for a state is 0.
- FETCH: mem_req_o = 1, iord_o = 0, alu a = PC, b = 4, op = 00. The state is held while mem_ready_i = 0. In the cycle mem_ready_i = 1: ir_write_o = 1, pc_write_o = 1 with pc_src = 0, then go to DECODE.
- DECODE: alu a = oldPC, b = imm, op = 00, which latches the branch/jump target into ALUOut. Dispatch on instr_i[6:0]:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → FAULT
- EXEC_R: a = rs1, b = rs2, op = 10, then WB_ALU. EXEC_I: a = rs1, b = imm, op = 10, then WB_ALU.
- WB_ALU: reg_write_o = 1, mem_to_reg = 0, then FETCH.
- MEM_ADDR: a = rs1, b = imm, op = 00. Go to MEM_RD if the opcode is load, else MEM_WR.
- MEM_RD / MEM_WR: mem_req_o = 1, iord_o = 1, mem_we_o = (MEM_WR). Held until mem_ready_i. On ready, MEM_RD goes to WB_MEM and MEM_WR goes to FETCH.
- WB_MEM: reg_write_o = 1, mem_to_reg = 1, then FETCH.
- BRANCH (beq only, funct3 = 000): a = rs1, b = rs2, op = 01. pc_write_o = zero_i with pc_src = 1, then FETCH. Any other funct3 → FAULT.
- JAL: reg_write_o = 1, mem_to_reg = 2, pc_write_o = 1 with pc_src = 2, then FETCH.
- Latency with zero-wait memory: R/I 4 cycles, lw 5, sw 4, beq 3, jal 3. Each wait cycle adds one.
- Wait counter:
  - Clears on entry to any memory state and increments each cycle mem_req_o = 1 with mem_ready_i = 0.
  - When the count reaches MEM_TIMEOUT with no ready, go to FAULT.
  - A ready arriving in the same cycle the count reaches MEM_TIMEOUT wins: the access completes normally.
- FAULT: fault_o = 1 and all enables are 0. Terminal until reset.
- rd = x0 writes are still issued; the register file discards them.

Decomposition:
- Package mc_pkg holds:
  - state enum: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, FAULT (4-bit);
  - opcode constants;
  - encodings for alu_src_a/b, pc_src, mem_to_reg and alu_op.
- One sub-module, mc_mem_timer, implements the wait counter with clear/inc/expired.

Test Plan:
- add x3,x1,x2 with zero-wait memory → states FETCH, DECODE, EXEC_R, WB_ALU; reg_write_o high exactly in cycle 4; pc_write_o only in cycle 1.
- lw with mem_ready_i delayed 3 cycles in MEM_RD → mem_req_o = 1, iord_o = 1 for 4 cycles, then WB_MEM with mem_to_reg = 1; total 8 cycles.
- beq: once with zero_i = 1 → pc_write_o = 1, pc_src = 1 in cycle 3; once with zero_i = 0 → no PC write; both return to FETCH.
- Opcode 0x7F, and separately mem_ready_i held low for 16 cycles in FETCH → FAULT, fault_o = 1 and stays high; ready on exactly cycle 16 → normal completion.
- rst_i pulsed low mid-MEM_WR → asynchronous return to FETCH with mem_req_o = 0 immediately and fault_o = 0, and no write.
